estacion_ingreso: RTL and testbench
===================================

Name: estacion_ingreso

Overview:
- Driver side of the parking-gate access interface. Sits between the field hardware (arrival sensor, pass-through sensor, keypad) and the gate controller.
- Assembles a 2-digit BCD PIN from keypad strokes and drives Vehiculo, Pin, Pin_valido and Termino toward the controller.
- Tracks the controller's Cerrado/Abierto/Alarma/Bloqueo responses to sequence each vehicle's transaction, including retries, timeouts and lockout.

Parameters:
- T_RESP, 16: cycles to wait for a controller response after Pin_valido before declaring timeout.
- T_PASO, 255: cycles to wait for Sensor_paso after Abierto before forcing Termino.
- CW, 8: width of the internal timeout counter; must satisfy 2^CW > max(T_RESP, T_PASO).

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Sensor_llegada  in  1  level; vehicle present at gate.
- Sensor_paso  in  1  level; vehicle crossing gate line.
- Tecla  in  4  BCD keypad digit; values 10..15 are ignored.
- Tecla_valida  in  1  one-cycle strobe qualifying Tecla.
- Cerrado  in  1  controller: gate closed.
- Abierto  in  1  controller: gate open (PIN accepted).
- Alarma  in  1  controller: wrong-PIN alarm.
- Bloqueo  in  1  controller: lockout.
- Vehiculo  out  1  to controller; vehicle in transaction.
- Pin  out  8  to controller; {first digit, second digit}, held stable from Pin_valido until the next clear.
- Pin_valido  out  1  one-cycle strobe; Pin complete.
- Termino  out  1  one-cycle strobe; vehicle has passed.
- Intentos  out  2  PIN submissions in current transaction, saturating at 3.
- Ocupado  out  1  high in any state other than ESPERA.

Behaviour:
- Reset (synchronous, active-high): state ESPERA. Pin=0, Vehiculo=0, Pin_valido=0, Termino=0, Intentos=0, Ocupado=0, digit count=0, timer=0. Reset overrides every state, including mid-transaction and BLOQUEADO.
- ESPERA
  - Sensor_llegada=1 -> VEHICULO on the next cycle.
  - Vehiculo rises in the same cycle as the state change (1 cycle after sensor).
  - Keypad strokes are ignored in ESPERA.
- VEHICULO (Vehiculo=1)
  - Each Tecla_valida with Tecla<=9 shifts the digit in: first digit -> Pin[7:4], second -> Pin[3:0].
  - When the second digit is captured: Pin_valido=1 on the following cycle, Intentos increments (saturates at 3), timer cleared, -> RESPUESTA.
  - Sensor_llegada falling before the PIN completes -> ESPERA, with Vehiculo=0, Pin=0 and Intentos=0 next cycle.
- RESPUESTA (Vehiculo=1, keypad ignored)
  - Priority when inputs coincide: Bloqueo > Abierto > Alarma.
  - Bloqueo -> BLOQUEADO.
  - Abierto -> PASO, timer cleared.
  - Alarma -> VEHICULO, with Pin=0 and digit count=0 so the driver re-enters the PIN.
  - Timer reaching T_RESP with no response -> VEHICULO, with Pin cleared; Intentos is kept.
- PASO (Vehiculo=1)
  - Termino pulses for exactly 1 cycle on the first cycle Sensor_paso=1, or when the timer reaches T_PASO.
  - -> CIERRE on the same edge.
- CIERRE (Vehiculo=0)
  - Waits for Cerrado=1 and Sensor_llegada=0, then -> ESPERA, with Pin=0 and Intentos=0.
- BLOQUEADO (Vehiculo=1, keypad ignored)
  - Exits only when Bloqueo falls, then -> ESPERA with all transaction registers cleared.
  - Reset also exits this state.
- Strobe and digit rules
  - Pin_valido and Termino are never high in the same cycle.
  - Each is never high for more than 1 cycle per event.
  - Tecla_valida in the same cycle as a state exit from VEHICULO is dropped.
- Timer
  - CW-bit counter, cleared on entry to RESPUESTA and PASO.
  - Increments every cycle while in those states and never wraps; compare uses ==.

Test Plan:
1. Reset, Sensor_llegada=1, keys 4 then 2 -> Vehiculo=1 one cycle after sensor; Pin=8'h42 with a single Pin_valido pulse; Intentos=1. Then Abierto=1 and Sensor_paso=1 -> one Termino pulse. Then Cerrado=1 and sensor low -> ESPERA, Pin=0, Intentos=0.
2. Wrong PIN twice (Alarma after each) then correct PIN -> Pin cleared after each Alarma; Intentos=1,2,3; third submission accepted via Abierto. Enter a fourth PIN afterwards in a new transaction -> Intentos restarts at 1.
3. PIN submitted, no response for T_RESP=16 cycles -> return to VEHICULO on cycle 16 with Pin=0 and Intentos unchanged.
4. Bloqueo with Abierto in the same cycle -> BLOQUEADO (Bloqueo wins); keypad ignored. Bloqueo falls -> ESPERA, Vehiculo=0.
5. Abierto with Sensor_paso held 0 -> Termino pulses at exactly T_PASO cycles after entering PASO.
6. Reset asserted in PASO, and separately after only one digit entered -> all outputs 0 on the next cycle; invalid key Tecla=4'hB -> digit ignored, Pin unchanged.

Source files
------------

// File: rtl/estacion_ingreso.sv
// Parking-gate driver: builds a 2-digit BCD PIN from the keypad and sequences each vehicle's transaction with the gate controller.
// Outputs are registered or state-decoded, one cycle after the sampled input. There is no backpressure: strobes are single-cycle and the controller must take them.
module estacion_ingreso #(
  parameter int T_RESP = 16,
  parameter int T_PASO = 255,
  parameter int CW     = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Sensor_llegada,
  input  logic       Sensor_paso,
  input  logic [3:0] Tecla,
  input  logic       Tecla_valida,
  input  logic       Cerrado,
  input  logic       Abierto,
  input  logic       Alarma,
  input  logic       Bloqueo,
  output logic       Vehiculo,
  output logic [7:0] Pin,
  output logic       Pin_valido,
  output logic       Termino,
  output logic [1:0] Intentos,
  output logic       Ocupado
);

  typedef enum logic [2:0] {
    ESPERA, VEHICULO, RESPUESTA, PASO, CIERRE, BLOQUEADO
  } estado_t;

  localparam logic [CW-1:0] LIM_RESP = CW'(T_RESP);
  localparam logic [CW-1:0] LIM_PASO = CW'(T_PASO);

  estado_t       estado, estado_sig;
  logic [7:0]    pin_sig;
  logic          digito, digito_sig;
  logic [1:0]    intentos_sig;
  logic [CW-1:0] timer, timer_sig, timer_inc;
  logic          pin_valido_sig, termino_sig;
  logic          tecla_ok;

  assign tecla_ok  = Tecla_valida && (Tecla <= 4'd9);
  // Timeouts compare against the value the timer is about to take, so the exit lands exactly on the limit.
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  assign Vehiculo = (estado == VEHICULO) || (estado == RESPUESTA) ||
                    (estado == PASO) || (estado == BLOQUEADO);
  assign Ocupado  = (estado != ESPERA);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado     <= ESPERA;
      Pin        <= '0;
      digito     <= 1'b0;
      Intentos   <= '0;
      timer      <= '0;
      Pin_valido <= 1'b0;
      Termino    <= 1'b0;
    end else begin
      estado     <= estado_sig;
      Pin        <= pin_sig;
      digito     <= digito_sig;
      Intentos   <= intentos_sig;
      timer      <= timer_sig;
      Pin_valido <= pin_valido_sig;
      Termino    <= termino_sig;
    end
  end

  always_comb begin
    estado_sig     = estado;
    pin_sig        = Pin;
    digito_sig     = digito;
    intentos_sig   = Intentos;
    timer_sig      = timer;
    pin_valido_sig = 1'b0;
    termino_sig    = 1'b0;

    case (estado)
      ESPERA: begin
        if (Sensor_llegada) estado_sig = VEHICULO;
      end

      VEHICULO: begin
        // Departure beats a coincident keystroke.
        if (!Sensor_llegada) begin
          estado_sig   = ESPERA;
          pin_sig      = '0;
          digito_sig   = 1'b0;
          intentos_sig = '0;
        end else if (tecla_ok) begin
          if (!digito) begin
            pin_sig    = {Tecla, 4'h0};
            digito_sig = 1'b1;
          end else begin
            pin_sig        = {Pin[7:4], Tecla};
            digito_sig     = 1'b0;
            pin_valido_sig = 1'b1;
            intentos_sig   = (Intentos == 2'd3) ? 2'd3 : Intentos + 2'd1;
            timer_sig      = '0;
            estado_sig     = RESPUESTA;
          end
        end
      end

      RESPUESTA: begin
        timer_sig = timer_inc;
        if (Bloqueo) begin
          estado_sig = BLOQUEADO;
        end else if (Abierto) begin
          estado_sig = PASO;
          timer_sig  = '0;
        end else if (Alarma || (timer_inc == LIM_RESP)) begin
          estado_sig = VEHICULO;
          pin_sig    = '0;
          digito_sig = 1'b0;
        end
      end

      PASO: begin
        timer_sig = timer_inc;
        if (Sensor_paso || (timer_inc == LIM_PASO)) begin
          termino_sig = 1'b1;
          estado_sig  = CIERRE;
        end
      end

      CIERRE: begin
        if (Cerrado && !Sensor_llegada) begin
          estado_sig   = ESPERA;
          pin_sig      = '0;
          digito_sig   = 1'b0;
          intentos_sig = '0;
        end
      end

      BLOQUEADO: begin
        if (!Bloqueo) begin
          estado_sig   = ESPERA;
          pin_sig      = '0;
          digito_sig   = 1'b0;
          intentos_sig = '0;
          timer_sig    = '0;
        end
      end

      default: estado_sig = ESPERA;
    endcase
  end

endmodule

// File: tb/tb_estacion_ingreso.sv
// Bench for estacion_ingreso: directed scenarios followed by randomized transactions checked against transaction-level expectations.
module tb_estacion_ingreso;

  localparam int T_RESP = 16;
  localparam int T_PASO = 255;

  logic       Clk = 1'b0;
  logic       Reset, Sensor_llegada, Sensor_paso, Tecla_valida;
  logic       Cerrado, Abierto, Alarma, Bloqueo;
  logic [3:0] Tecla;
  logic       Vehiculo, Pin_valido, Termino, Ocupado;
  logic [7:0] Pin;
  logic [1:0] Intentos;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_pin;
  int         exp_int;

  estacion_ingreso #(.T_RESP(T_RESP), .T_PASO(T_PASO), .CW(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Sensor_llegada(Sensor_llegada), .Sensor_paso(Sensor_paso),
    .Tecla(Tecla), .Tecla_valida(Tecla_valida),
    .Cerrado(Cerrado), .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo),
    .Vehiculo(Vehiculo), .Pin(Pin), .Pin_valido(Pin_valido), .Termino(Termino),
    .Intentos(Intentos), .Ocupado(Ocupado)
  );

  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_veh", Vehiculo, 0);
    chk("idle_pin", Pin, 0);
    chk("idle_pv", Pin_valido, 0);
    chk("idle_term", Termino, 0);
    chk("idle_int", Intentos, 0);
    chk("idle_ocup", Ocupado, 0);
  endtask

  task automatic key(input logic [3:0] t);
    Tecla = t;
    Tecla_valida = 1'b1;
    tick();
    Tecla_valida = 1'b0;
  endtask

  // Keys pressed while idle are ignored; Vehiculo rises one cycle after the sensor.
  task automatic arrive();
    key(4'($urandom_range(1, 9)));
    chk("espera_pin", Pin, 0);
    chk("espera_veh", Vehiculo, 0);
    Sensor_llegada = 1'b1;
    tick();
    chk("arrive_veh", Vehiculo, 1);
    chk("arrive_ocup", Ocupado, 1);
    chk("arrive_pin", Pin, 0);
  endtask

  // Ends one cycle after the Pin_valido cycle.
  task automatic enter_pin(input logic [3:0] d1, input logic [3:0] d2, input int attempt);
    exp_int = (attempt > 3) ? 3 : attempt;
    exp_pin = {d1, d2};
    chk("pin_pre", Pin, 0);
    key(4'(10 + $urandom_range(0, 5)));
    chk("pin_inv0", Pin, 0);
    key(d1);
    chk("pin_d1", Pin, {d1, 4'h0});
    chk("pv_d1", Pin_valido, 0);
    repeat ($urandom_range(0, 3)) tick();
    key(4'hB);
    chk("pin_invB", Pin, {d1, 4'h0});
    key(d2);
    chk("pin_d2", Pin, exp_pin);
    chk("pv_hi", Pin_valido, 1);
    chk("pv_term", Termino, 0);
    chk("intentos", Intentos, exp_int);
    tick();
    chk("pv_lo", Pin_valido, 0);
  endtask

  task automatic rsp_alarma();
    key(4'($urandom_range(0, 9)));
    chk("resp_key", Pin, exp_pin);
    repeat ($urandom_range(0, 6)) tick();
    Alarma = 1'b1;
    tick();
    Alarma = 1'b0;
    chk("alarma_pin", Pin, 0);
    chk("alarma_veh", Vehiculo, 1);
    chk("alarma_int", Intentos, exp_int);
  endtask

  // Pin_valido cycle is cycle 0; Pin must drop exactly at cycle T_RESP.
  task automatic rsp_timeout();
    int c;
    c = 1;
    while (Pin !== 8'h00 && c < 4 * T_RESP) begin
      tick();
      c++;
    end
    chk("t_resp", c, T_RESP);
    chk("to_veh", Vehiculo, 1);
    chk("to_int", Intentos, exp_int);
  endtask

  // Sensor_paso raised during PASO cycle d: Termino expected at cycle min(d+1, T_PASO).
  task automatic rsp_abierto(input int d, input bit with_alarma);
    int c;
    int exp_c;
    repeat ($urandom_range(0, 5)) tick();
    Abierto = 1'b1;
    Alarma  = with_alarma;
    tick();
    Abierto = 1'b0;
    Alarma  = 1'b0;
    chk("paso_veh", Vehiculo, 1);
    chk("paso_pin", Pin, exp_pin);
    c = 0;
    while (Termino !== 1'b1 && c < T_PASO + 20) begin
      Sensor_paso = (c >= d);
      tick();
      c++;
    end
    exp_c = (d + 1 < T_PASO) ? d + 1 : T_PASO;
    chk("t_paso", c, exp_c);
    chk("cierre_veh", Vehiculo, 0);
    chk("cierre_pv", Pin_valido, 0);
    chk("cierre_pin", Pin, exp_pin);
    tick();
    chk("term_1cyc", Termino, 0);
    Sensor_paso = 1'b0;
    Cerrado = 1'b1;
    tick();
    chk("cierre_hold", Ocupado, 1);
    Sensor_llegada = 1'b0;
    tick();
    Cerrado = 1'b0;
    chk_idle();
  endtask

  task automatic rsp_bloqueo(input bit with_abierto);
    repeat ($urandom_range(0, 5)) tick();
    Bloqueo = 1'b1;
    Abierto = with_abierto;
    tick();
    Abierto = 1'b0;
    chk("bloq_veh", Vehiculo, 1);
    chk("bloq_ocup", Ocupado, 1);
    key(4'($urandom_range(0, 9)));
    chk("bloq_key", Pin, exp_pin);
    Sensor_paso = 1'b1;
    tick();
    Sensor_paso = 1'b0;
    chk("bloq_term", Termino, 0);
    Sensor_llegada = 1'b0;
    repeat (2) tick();
    chk("bloq_hold", Vehiculo, 1);
    chk("bloq_int", Intentos, exp_int);
    Bloqueo = 1'b0;
    tick();
    chk_idle();
  endtask

  initial begin
    Reset = 1'b1;
    Sensor_llegada = 1'b0;
    Sensor_paso = 1'b0;
    Tecla = 4'h0;
    Tecla_valida = 1'b0;
    Cerrado = 1'b0;
    Abierto = 1'b0;
    Alarma = 1'b0;
    Bloqueo = 1'b0;
    exp_pin = 8'h00;
    exp_int = 0;
    tick();
    tick();
    Reset = 1'b0;
    chk_idle();

    // Basic accepted transaction with PIN 42.
    arrive();
    enter_pin(4'd4, 4'd2, 1);
    rsp_abierto(0, 1'b0);

    // Two alarms then acceptance (Abierto beats a coincident Alarma); new transaction restarts the count.
    arrive();
    enter_pin(4'd1, 4'd3, 1);
    rsp_alarma();
    enter_pin(4'd2, 4'd5, 2);
    rsp_alarma();
    enter_pin(4'd4, 4'd2, 3);
    rsp_abierto(3, 1'b1);
    arrive();
    enter_pin(4'd9, 4'd9, 1);
    rsp_abierto(7, 1'b0);

    // Response timeout, saturation at 3, then lockout with a coincident Abierto.
    arrive();
    enter_pin(4'd1, 4'd1, 1);
    rsp_timeout();
    enter_pin(4'd2, 4'd2, 2);
    rsp_alarma();
    enter_pin(4'd3, 4'd3, 3);
    rsp_alarma();
    enter_pin(4'd5, 4'd6, 4);
    rsp_bloqueo(1'b1);

    // Vehicle never crosses: Termino forced at T_PASO.
    arrive();
    enter_pin(4'd6, 4'd1, 1);
    rsp_abierto(100000, 1'b0);

    // Vehicle leaves mid-entry; the coincident keystroke is dropped.
    arrive();
    enter_pin(4'd1, 4'd2, 1);
    rsp_alarma();
    key(4'd5);
    chk("abandon_d1", Pin, 8'h50);
    Sensor_llegada = 1'b0;
    Tecla = 4'd6;
    Tecla_valida = 1'b1;
    tick();
    Tecla_valida = 1'b0;
    chk_idle();

    // Reset in PASO, and after a single digit.
    arrive();
    enter_pin(4'd8, 4'd3, 1);
    Abierto = 1'b1;
    tick();
    Abierto = 1'b0;
    chk("rst_paso_veh", Vehiculo, 1);
    Reset = 1'b1;
    Sensor_llegada = 1'b0;
    tick();
    Reset = 1'b0;
    chk_idle();
    arrive();
    key(4'd3);
    chk("rst_d1", Pin, 8'h30);
    Reset = 1'b1;
    Sensor_llegada = 1'b0;
    tick();
    Reset = 1'b0;
    chk_idle();

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      int nfail;
      nfail = $urandom_range(0, 3);
      arrive();
      for (int a = 1; a <= nfail + 1; a++) begin
        enter_pin(4'($urandom_range(1, 9)), 4'($urandom_range(0, 9)), a);
        if (a <= nfail) begin
          if ($urandom_range(0, 1) == 1) rsp_alarma();
          else rsp_timeout();
        end
      end
      case ($urandom_range(0, 5))
        0:       rsp_bloqueo($urandom_range(0, 1) == 1);
        1:       rsp_abierto(100000, $urandom_range(0, 1) == 1);
        default: rsp_abierto(int'($urandom_range(0, 20)), $urandom_range(0, 1) == 1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
